mux_d: RTL and testbench
========================

Name: mux_d

Overview:
- Parameterized 4-input, width-bit multiplexer with a registered output stage.
- On each enabled clock edge it captures the input chosen by sel onto o.
- Used as a clocked data-routing element wherever one of four equal-width buses must be forwarded with a fixed one-cycle latency.

Parameters:
- width, 4, bit width of each data input and of o.
- swidth, 2, select width; fixed at 2 for the four inputs. Any other value is a configuration error, flagged at elaboration.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, capture enable.
- i0, input, width, data input selected by sel=0.
- i1, input, width, data input selected by sel=1.
- i2, input, width, data input selected by sel=2.
- i3, input, width, data input selected by sel=3.
- sel, input, swidth, input select.
- o, output, width, registered selected data.
- o_valid, output, 1, high for one cycle after each enabled capture.
- o_sel, output, swidth, registered copy of the sel value that produced o.

Behaviour:
- One clock (clk) for everything; reset is synchronous and active-high (rst). All state changes happen on the rising edge of clk.
- Reset: when rst=1 at an edge, o=0, o_valid=0 and o_sel=0. rst has priority over en.
- Mapping: sel=00 gives i0, 01 gives i1, 10 gives i2, 11 gives i3. The full sel range is decoded, so there is no default or X case.
- Capture: when rst=0 and en=1 at an edge:
  - o takes the value of the selected input sampled at that edge.
  - o_sel takes sel.
  - o_valid goes to 1.
- Hold: when rst=0 and en=0 at an edge, o and o_sel hold their values and o_valid goes to 0.
- Latency: exactly one clock from input/sel sampling to o. There is no combinational path from any input to any output.
- Back-to-back captures: with en held at 1, o updates every cycle and o_valid stays at 1.
- Changing sel or data between edges has no effect on outputs until the next enabled edge.
- Reset mid-stream: rst=1 overrides a pending capture on the same edge. The first capture after reset deasserts happens on the first edge with rst=0 and en=1.
- Width rules: pure bit copy with no extension or truncation, for any width of 1 or more.
- After power-up, outputs are undefined until the first reset edge. The bench must apply reset first.

Optional Feature:
- Macro MUX_D_PARITY_EN.
- When defined: adds output o_par (1 bit), registered alongside o, equal to the XOR-reduction of the selected input captured on the same edge.
  - Reset value 0.
  - Holds with o when en=0.
- When not defined: the o_par port does not exist and the behaviour of all other ports is unchanged.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, i0=A, sel=0 -> o=0, o_valid=0, o_sel=0 throughout.
- sel=00: en=1, i0=A, i1=B, i2=C, i3=D, then i0=B, i1=C, i2=D, i3=E -> o=A, then o=B one cycle after each; o_sel=0, o_valid=1.
- sel=01: i0..i3=C,D,E,F, then D,E,F,A -> o=D, then E; o_sel=1.
- sel=10 with E,F,A,B then F,A,B,C, and sel=11 with A,B,C,D then B,C,D,E -> o=A, B, D, E respectively, each one cycle after its inputs; o_sel tracks sel.
- Hold: capture o=D, then en=0 with i3=5 and sel=0 -> o stays D, o_sel stays 3, o_valid=0. Then en=1 -> o=new i0.
- Reset priority: rst=1 and en=1 on the same edge while o=F -> o=0, o_valid=0. With MUX_D_PARITY_EN: selecting 4'hB gives o_par=1, and 4'hA gives o_par=0.

Source files
------------

// File: rtl/mux_d_if.sv
// Bus bundle for mux_d: enable, four data inputs and select in; registered data, valid and select out.
// o_par is present only when MUX_D_PARITY_EN is defined.
interface mux_d_if #(
    parameter int width  = 4,
    parameter int swidth = 2
);
    logic              en;
    logic [width-1:0]  i0;
    logic [width-1:0]  i1;
    logic [width-1:0]  i2;
    logic [width-1:0]  i3;
    logic [swidth-1:0] sel;
    logic [width-1:0]  o;
    logic              o_valid;
    logic [swidth-1:0] o_sel;
`ifdef MUX_D_PARITY_EN
    logic              o_par;
`endif

`ifdef MUX_D_PARITY_EN
    modport master (
        output en, i0, i1, i2, i3, sel,
        input  o, o_valid, o_sel, o_par
    );
    modport slave (
        input  en, i0, i1, i2, i3, sel,
        output o, o_valid, o_sel, o_par
    );
`else
    modport master (
        output en, i0, i1, i2, i3, sel,
        input  o, o_valid, o_sel
    );
    modport slave (
        input  en, i0, i1, i2, i3, sel,
        output o, o_valid, o_sel
    );
`endif
endinterface

// File: rtl/mux_d.sv
// Registered 4:1 multiplexer with one-cycle latency, capture enable and a valid strobe.
// Optional macro MUX_D_PARITY_EN adds o_par, the XOR-reduction of the captured word.
module mux_d #(
    parameter int width  = 4,
    parameter int swidth = 2
) (
    input  logic     clk,
    input  logic     rst,
    mux_d_if.slave   bus
);

    generate
        if (swidth != 2) begin : g_bad_swidth
            $error("mux_d: swidth must be 2 for four inputs");
        end
        if (width < 1) begin : g_bad_width
            $error("mux_d: width must be at least 1");
        end
    endgenerate

    logic [width-1:0]  pick;
    logic [width-1:0]  o_q;
    logic              valid_q;
    logic [swidth-1:0] sel_q;
    logic              par_q;

    // Every sel value is decoded, so the leading assignment only keeps the block latch-free.
    always_comb begin
        pick = bus.i0;
        case (bus.sel)
            2'd0: pick = bus.i0;
            2'd1: pick = bus.i1;
            2'd2: pick = bus.i2;
            2'd3: pick = bus.i3;
        endcase
    end

    // Reset wins over enable; without enable the data holds but the strobe drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q     <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            valid_q <= bus.en;
            if (bus.en) begin
                o_q   <= pick;
                sel_q <= bus.sel;
                par_q <= ^pick;
            end
        end
    end

    assign bus.o       = o_q;
    assign bus.o_valid = valid_q;
    assign bus.o_sel   = sel_q;
`ifdef MUX_D_PARITY_EN
    assign bus.o_par   = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_mux_d.sv
// Self-checking bench for mux_d: directed plan scenarios plus randomized traffic
// compared against an array-indexing reference model.
module tb_mux_d;

    localparam int W = 8;
`ifdef MUX_D_PARITY_EN
    localparam int OW = W + 1 + 2 + 1;
`else
    localparam int OW = W + 1 + 2;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [W-1:0] m_o;
    logic         m_valid;
    logic [1:0]   m_sel;
    logic         m_par;

    mux_d_if #(.width(W), .swidth(2)) bus ();

    mux_d #(.width(W), .swidth(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] observed();
`ifdef MUX_D_PARITY_EN
        return {bus.o, bus.o_valid, bus.o_sel, bus.o_par};
`else
        return {bus.o, bus.o_valid, bus.o_sel};
`endif
    endfunction

    function automatic logic [OW-1:0] model_vec();
`ifdef MUX_D_PARITY_EN
        return {m_o, m_valid, m_sel, m_par};
`else
        return {m_o, m_valid, m_sel};
`endif
    endfunction

    function automatic logic [OW-1:0] make_vec(logic [W-1:0] o, logic v, logic [1:0] s);
`ifdef MUX_D_PARITY_EN
        return {o, v, s, ^o};
`else
        return {o, v, s};
`endif
    endfunction

    // Drive one edge's worth of inputs at the falling edge, then advance the model past the rising edge.
    task automatic apply_stimulus(input logic r, input logic e, input logic [1:0] s,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] v [4];
        @(negedge clk);
        rst = r; bus.en = e; bus.sel = s;
        bus.i0 = a; bus.i1 = b; bus.i2 = c; bus.i3 = d;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        @(posedge clk);
        #1;
        if (r) begin
            m_o = '0; m_valid = 1'b0; m_sel = 2'd0; m_par = 1'b0;
        end else if (e) begin
            m_o = v[s]; m_valid = 1'b1; m_sel = s; m_par = ^v[s];
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(1'b1, 1'b1, 2'd0, 8'h0A, 8'h0B, 8'h0C, 8'h0D);
            checks++;
            if (observed() !== make_vec('0, 1'b0, 2'd0)) begin
                failures++;
                $display("[TB] FAIL reset[%0d]: got %h expected %h", k, observed(), make_vec('0, 1'b0, 2'd0));
            end
        end
    endtask

    task automatic test_select();
        logic [W-1:0] sets [4][2][4];
        logic [W-1:0] want [4][2];
        sets[0][0] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D}; sets[0][1] = '{8'h0B, 8'h0C, 8'h0D, 8'h0E};
        sets[1][0] = '{8'h0C, 8'h0D, 8'h0E, 8'h0F}; sets[1][1] = '{8'h0D, 8'h0E, 8'h0F, 8'h0A};
        sets[2][0] = '{8'h0E, 8'h0F, 8'h0A, 8'h0B}; sets[2][1] = '{8'h0F, 8'h0A, 8'h0B, 8'h0C};
        sets[3][0] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D}; sets[3][1] = '{8'h0B, 8'h0C, 8'h0D, 8'h0E};
        want[0] = '{8'h0A, 8'h0B}; want[1] = '{8'h0D, 8'h0E};
        want[2] = '{8'h0A, 8'h0B}; want[3] = '{8'h0D, 8'h0E};
        for (int s = 0; s < 4; s++) begin
            for (int p = 0; p < 2; p++) begin
                apply_stimulus(1'b0, 1'b1, 2'(s), sets[s][p][0], sets[s][p][1], sets[s][p][2], sets[s][p][3]);
                checks++;
                if (observed() !== make_vec(want[s][p], 1'b1, 2'(s))) begin
                    failures++;
                    $display("[TB] FAIL select sel=%0d step=%0d: got %h expected %h",
                             s, p, observed(), make_vec(want[s][p], 1'b1, 2'(s)));
                end
            end
        end
    endtask

    task automatic test_hold();
        apply_stimulus(1'b0, 1'b1, 2'd3, 8'h01, 8'h02, 8'h03, 8'h0D);
        checks++;
        if (observed() !== make_vec(8'h0D, 1'b1, 2'd3)) begin
            failures++;
            $display("[TB] FAIL hold_capture: got %h expected %h", observed(), make_vec(8'h0D, 1'b1, 2'd3));
        end
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(1'b0, 1'b0, 2'd0, 8'h07, 8'h02, 8'h03, 8'h05);
            checks++;
            if (observed() !== make_vec(8'h0D, 1'b0, 2'd3)) begin
                failures++;
                $display("[TB] FAIL hold[%0d]: got %h expected %h", k, observed(), make_vec(8'h0D, 1'b0, 2'd3));
            end
        end
        apply_stimulus(1'b0, 1'b1, 2'd0, 8'h07, 8'h02, 8'h03, 8'h05);
        checks++;
        if (observed() !== make_vec(8'h07, 1'b1, 2'd0)) begin
            failures++;
            $display("[TB] FAIL hold_release: got %h expected %h", observed(), make_vec(8'h07, 1'b1, 2'd0));
        end
    endtask

    task automatic test_between_edges();
        apply_stimulus(1'b0, 1'b1, 2'd2, 8'h11, 8'h22, 8'h33, 8'h44);
        bus.sel = 2'd1; bus.i1 = 8'h99; bus.i2 = 8'h77;
        #2;
        checks++;
        if (observed() !== make_vec(8'h33, 1'b1, 2'd2)) begin
            failures++;
            $display("[TB] FAIL between_edges: got %h expected %h", observed(), make_vec(8'h33, 1'b1, 2'd2));
        end
    endtask

    task automatic test_reset_priority();
        apply_stimulus(1'b0, 1'b1, 2'd1, 8'h00, 8'h0F, 8'h00, 8'h00);
        checks++;
        if (observed() !== make_vec(8'h0F, 1'b1, 2'd1)) begin
            failures++;
            $display("[TB] FAIL prio_capture: got %h expected %h", observed(), make_vec(8'h0F, 1'b1, 2'd1));
        end
        apply_stimulus(1'b1, 1'b1, 2'd1, 8'h00, 8'h0F, 8'h00, 8'h00);
        checks++;
        if (observed() !== make_vec('0, 1'b0, 2'd0)) begin
            failures++;
            $display("[TB] FAIL prio_reset: got %h expected %h", observed(), make_vec('0, 1'b0, 2'd0));
        end
        apply_stimulus(1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 8'h0B, 8'h00);
        checks++;
        if (observed() !== make_vec(8'h0B, 1'b1, 2'd2)) begin
            failures++;
            $display("[TB] FAIL prio_first_after: got %h expected %h", observed(), make_vec(8'h0B, 1'b1, 2'd2));
        end
`ifdef MUX_D_PARITY_EN
        checks++;
        if (bus.o_par !== 1'b1) begin
            failures++;
            $display("[TB] FAIL parity_0B: got %b expected 1", bus.o_par);
        end
        apply_stimulus(1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 8'h0A, 8'h00);
        checks++;
        if (bus.o_par !== 1'b0) begin
            failures++;
            $display("[TB] FAIL parity_0A: got %b expected 0", bus.o_par);
        end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            apply_stimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                           2'($urandom_range(0, 3)),
                           W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            checks++;
            if (observed() !== model_vec()) begin
                failures++;
                $display("[TB] FAIL random[%0d]: got %h expected %h", n, observed(), model_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; bus.en = 1'b0; bus.sel = 2'd0;
        bus.i0 = '0; bus.i1 = '0; bus.i2 = '0; bus.i3 = '0;
        m_o = '0; m_valid = 1'b0; m_sel = 2'd0; m_par = 1'b0;
        test_reset();
        test_select();
        test_hold();
        test_between_edges();
        test_reset_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
